// File: rtl/mux_n_pipe.sv
// mux_n_pipe: registered N-way selector with a valid/ready output stage.
// The source is chosen either by a loadable select register (fixed mode) or
// by a round-robin arbiter (scan mode). The chosen word is registered
// together with its source index, which cuts long select paths by one flop.
// Optional feature: define MUX_N_PIPE_ERR_EN to build the sticky sel_err flag.

// Per-source accept decode: lane LANE is ready when the stage may accept
// and the active select points at this lane.
module mux_n_pipe_lane #(
    parameter int SEL_W = 3,
    parameter int LANE  = 0
) (
    input  logic             enable,
    input  logic [SEL_W-1:0] sel,
    output logic             hot
);
    localparam logic [SEL_W-1:0] IDX = SEL_W'(LANE);

    assign hot = enable && (sel == IDX);
endmodule

module mux_n_pipe #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 7,
    parameter int SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_IN*WIDTH-1:0] in_flat,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]      seletor,
    input  logic                  sel_load,
    input  logic                  scan_mode,
    output logic [WIDTH-1:0]      out,
    output logic [SEL_W-1:0]      out_src,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err
);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_IN - 1);

    logic [N_IN-1:0][WIDTH-1:0] in_words;
    logic [SEL_W-1:0]           sel_q;
    logic [SEL_W-1:0]           rr_ptr;
    logic                       scan_q;
    logic                       free;
    logic                       sel_ok;
    logic [SEL_W-1:0]           rr_idx;
    logic                       rr_any;
    logic [SEL_W-1:0]           src;
    logic                       grant_en;
    logic                       xfer;

    assign in_words = in_flat;
    assign free     = !out_valid || out_ready;
    assign sel_ok   = int'(sel_q) < N_IN;

    // Round-robin search: pick the valid source with the smallest distance
    // past rr_ptr, wrapping from N_IN-1 back to 0.
    always_comb begin
        int best;
        int d;
        best   = N_IN;
        rr_idx = '0;
        rr_any = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            d = i - int'(rr_ptr) - 1;
            if (d < 0) d = d + N_IN;
            if (in_valid[i] && d < best) begin
                best   = d;
                rr_idx = SEL_W'(i);
                rr_any = 1'b1;
            end
        end
    end

    // An out-of-range fixed select never enables a lane, so nothing is taken.
    assign src      = scan_mode ? rr_idx : sel_q;
    assign grant_en = reset_n && free && (scan_mode ? rr_any : sel_ok);
    assign xfer     = |(in_ready & in_valid);

    for (genvar g = 0; g < N_IN; g++) begin : g_lane
        mux_n_pipe_lane #(.SEL_W(SEL_W), .LANE(g)) u_lane (
            .enable (grant_en),
            .sel    (src),
            .hot    (in_ready[g])
        );
    end

    // Output register, select register and arbiter pointer. A transfer uses
    // the pre-load select and beats the scan-entry pointer reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_q     <= '0;
            rr_ptr    <= LAST;
            scan_q    <= 1'b0;
            out       <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
        end else begin
            scan_q <= scan_mode;
            if (sel_load) sel_q <= seletor;
            if (xfer) begin
                out       <= in_words[src];
                out_src   <= src;
                out_valid <= 1'b1;
                if (scan_mode) rr_ptr <= src;
            end else begin
                if (out_ready) out_valid <= 1'b0;
                if (scan_mode && !scan_q) rr_ptr <= LAST;
            end
        end
    end

`ifdef MUX_N_PIPE_ERR_EN
    logic err_q;

    // Sticky out-of-range flag; a valid reload clears it and wins over a set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (sel_load && int'(seletor) < N_IN) begin
            err_q <= 1'b0;
        end else if (!scan_mode && !sel_ok) begin
            err_q <= 1'b1;
        end
    end

    assign sel_err = err_q;
`else
    assign sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe (WIDTH=32, N_IN=7, SEL_W=3).
// Source i carries 32'hDEAD_0000 | i unless a step overrides it.
module tb_mux_n_pipe;
    localparam int WIDTH = 32;
    localparam int N_IN  = 7;
    localparam int SEL_W = 3;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [N_IN*WIDTH-1:0] in_flat;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN-1:0]       in_ready;
    logic [SEL_W-1:0]      seletor;
    logic                  sel_load;
    logic                  scan_mode;
    logic [WIDTH-1:0]      dout;
    logic [SEL_W-1:0]      out_src;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sel_err;

    int vectors = 0;
    int miscompares = 0;

    mux_n_pipe #(.WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_flat   (in_flat),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seletor   (seletor),
        .sel_load  (sel_load),
        .scan_mode (scan_mode),
        .out       (dout),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [WIDTH-1:0] v);
        in_flat[i*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        logic [SEL_W-1:0] rr_exp [6];
        rr_exp = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd0, 3'd1};

        for (int i = 0; i < N_IN; i++) set_src(i, 32'hDEAD_0000 | i);
        reset_n = 1'b0; in_valid = 7'h7F; seletor = '0; sel_load = 1'b0;
        scan_mode = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out", 64'(dout), 64'h0);
        chk("rst_src", 64'(out_src), 64'h0);
        chk("rst_vld", 64'(out_valid), 64'h0);
        chk("rst_rdy", 64'(in_ready), 64'h0);
        chk("rst_err", 64'(sel_err), 64'h0);

        // Fixed mode: load select 3 with no sources valid.
        reset_n = 1'b1; in_valid = 7'h00; sel_load = 1'b1; seletor = 3'd3;
        #1 chk("fix_rdy_sel0", 64'(in_ready), 64'h01);
        tick();
        sel_load = 1'b0; in_valid = 7'h7F;
        #1 chk("fix_rdy_sel3", 64'(in_ready), 64'h08);
        chk("fix_vld_pre", 64'(out_valid), 64'h0);
        tick();
        chk("fix_out", 64'(dout), 64'hDEAD_0003);
        chk("fix_src", 64'(out_src), 64'h3);
        chk("fix_vld", 64'(out_valid), 64'h1);
        chk("fix_rdy_thru", 64'(in_ready), 64'h08);

        // Backpressure: output must freeze even though source 3 changes.
        out_ready = 1'b0; set_src(3, 32'hBEEF_0003);
        for (int c = 0; c < 4; c++) begin
            #1 chk("bp_rdy", 64'(in_ready), 64'h0);
            chk("bp_out", 64'(dout), 64'hDEAD_0003);
            chk("bp_vld", 64'(out_valid), 64'h1);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_rdy", 64'(in_ready), 64'h08);
        tick();
        chk("bp_new_out", 64'(dout), 64'hBEEF_0003);
        chk("bp_new_vld", 64'(out_valid), 64'h1);
        in_valid = 7'h00;
        tick();
        chk("drain_vld", 64'(out_valid), 64'h0);
        chk("drain_hold", 64'(dout), 64'hBEEF_0003);

        // Same-cycle load: transfer from 1 while loading 5.
        sel_load = 1'b1; seletor = 3'd1;
        tick();
        seletor = 3'd5; in_valid = 7'h7F;
        tick();
        chk("same_src_old", 64'(out_src), 64'h1);
        chk("same_out_old", 64'(dout), 64'hDEAD_0001);
        sel_load = 1'b0;
        tick();
        chk("same_src_new", 64'(out_src), 64'h5);
        chk("same_out_new", 64'(dout), 64'hDEAD_0005);

        // Out-of-range select 7.
        sel_load = 1'b1; seletor = 3'd7;
        tick();
        sel_load = 1'b0;
        #1 chk("oor_rdy", 64'(in_ready), 64'h0);
        chk("oor_last_vld", 64'(out_valid), 64'h1);
        tick();
        chk("oor_no_vld", 64'(out_valid), 64'h0);
        chk("oor_out_hold", 64'(dout), 64'hDEAD_0005);
`ifdef MUX_N_PIPE_ERR_EN
        chk("oor_err_set", 64'(sel_err), 64'h1);
`else
        chk("oor_err_tied", 64'(sel_err), 64'h0);
`endif
        sel_load = 1'b1; seletor = 3'd2;
        tick();
        sel_load = 1'b0; in_valid = 7'h00;
        chk("oor_err_clr", 64'(sel_err), 64'h0);
        chk("oor_clr_vld", 64'(out_valid), 64'h0);

        // Round robin over sources 0,1,4,6.
        scan_mode = 1'b1; in_valid = 7'b1010011;
        #1 chk("rr_first_rdy", 64'(in_ready), 64'h01);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rr_src%0d", k), 64'(out_src), 64'(rr_exp[k]));
            chk($sformatf("rr_vld%0d", k), 64'(out_valid), 64'h1);
        end
        in_valid = 7'h00;
        tick();
        chk("rr_idle_vld", 64'(out_valid), 64'h0);
        chk("rr_idle_rdy", 64'(in_ready), 64'h0);

        // Leaving and re-entering scan mode resets the pointer (was 1).
        scan_mode = 1'b0;
        tick();
        scan_mode = 1'b1;
        tick();
        in_valid = 7'b0000110;
        #1 chk("rr_reentry_rdy", 64'(in_ready), 64'h02);

        // Reset while a word is stalled in the output stage.
        scan_mode = 1'b0; in_valid = 7'h7F;
        tick();
        chk("mid_out", 64'(dout), 64'hDEAD_0002);
        out_ready = 1'b0; reset_n = 1'b0;
        #1 chk("mid_rst_rdy", 64'(in_ready), 64'h0);
        tick();
        chk("mid_rst_vld", 64'(out_valid), 64'h0);
        chk("mid_rst_out", 64'(dout), 64'h0);
        chk("mid_rst_src", 64'(out_src), 64'h0);
        reset_n = 1'b1; out_ready = 1'b1;
        #1 chk("mid_rst_sel0", 64'(in_ready), 64'h01);
        tick();
        chk("post_rst_out", 64'(dout), 64'hDEAD_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised, registered N-way datapath selector with a valid/ready output handshake, the pipelined successor to the fixed 7-input combinational muxes in the multicycle datapath. It picks one of `N_IN` source words, by either a loadable select register (fixed mode) or a fair round-robin arbiter (scan mode). It registers the chosen word with its source index, so long select paths (PC/ALU/memory-address sources) are cut by one flop stage.

## Interface
- `WIDTH`, 32: data word width.
- `N_IN`, 7: number of sources, 2..16.
- `SEL_W`, 3: select width; must satisfy 2^SEL_W >= N_IN.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `in_flat`  in  N_IN*WIDTH  source words; source i at bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N_IN  per-source valid.
- `in_ready`  out  N_IN  one-hot (or zero) accept; source i transfers when `in_valid[i] & in_ready[i]`.
- `seletor`  in  SEL_W  new select value.
- `sel_load`  in  1  load `seletor` into the select register.
- `scan_mode`  in  1  0 = fixed select, 1 = round-robin.
- `out`  out  WIDTH  registered selected word.
- `out_src`  out  SEL_W  index of the source held in `out`.
- `out_valid`  out  1  `out`/`out_src` hold an untaken word.
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`.
- `sel_err`  out  1  sticky out-of-range select flag (see Configuration).

## Operation
- Reset (`reset_n`=0 at edge): `sel_q`=0, `rr_ptr`=N_IN-1, `out`=0, `out_src`=0, `out_valid`=0, `sel_err`=0. `in_ready` is 0 while `reset_n`=0.
- Stage free: `free = !out_valid | out_ready`. Each `in_ready` is 0 when `!free`.
- Fixed mode: `in_ready[sel_q] = free` if `sel_q < N_IN`, else all 0. On a transfer, `out` takes in_flat[sel_q], `out_src` takes `sel_q`, and `out_valid` is set to 1.
- Scan mode: grant the first valid index at or after `rr_ptr+1`, searching upward with wrap from N_IN-1 to 0. `in_ready` is one-hot on the grant when `free`. On a transfer, `rr_ptr` takes the granted index. With no valid source, nothing is granted and `rr_ptr` holds.
- If no transfer occurs and `out_ready` is 1, `out_valid` clears to 0. `out` and `out_src` hold their last values.
- `sel_load`: `sel_q` takes `seletor` at the edge. A transfer in the same cycle uses the old `sel_q`.
- `scan_mode` is sampled combinationally each cycle. A 0→1 transition resets `rr_ptr` to N_IN-1 at that edge, and the grant in that cycle still follows the ptr-based rule.
- Out-of-range `sel_q` (>= N_IN) in fixed mode: no source is accepted. Any word already in `out` drains normally. No zero word is emitted.

## Timing
- Latency: 1 cycle from the input transfer edge to `out_valid`=1.
- Throughput: 1 word/cycle while `out_ready` stays 1.
- Backpressure: while `out_valid & !out_ready`, `out` and `out_src` are stable and all `in_ready` are 0.
- Simultaneous drain and fill: in one cycle the output is taken and a new input transfers; `out_valid` stays 1 and `out` carries the new word.
- Select change: a `sel_load` at edge k affects `in_ready` from cycle k+1.
- Reset mid-transfer: a pending output word is discarded and `out_valid` is 0 after the edge.

## Configuration
- `MUX_N_PIPE_ERR_EN` defined: `sel_err` is set at any edge where fixed mode is active and `sel_q >= N_IN`. It clears only on reset or on a `sel_load` with `seletor < N_IN`; that load wins over a set in the same cycle.
- Macro undefined: `sel_err` is tied to 0 and no error logic is built. The out-of-range blocking behaviour is unchanged.

## Test plan
- Reset, then fixed mode: `sel_load`, `seletor`=3, `in_valid`=7'h7F, source3=32'hDEAD_0003, `out_ready`=1 → next cycle `out`=32'hDEAD_0003, `out_src`=3, `out_valid`=1; `in_ready`=7'b0001000 each cycle.
- Backpressure: `out_ready`=0 for 4 cycles with `out_valid`=1 → `out` is stable and `in_ready`=0. Raising `out_ready` drains one word per cycle.
- Round-robin: `scan_mode`=1, `in_valid`=7'b1010011, `out_ready`=1 → `out_src` sequence is 0, 1, 4, 6, 0, 1.
- Out-of-range: `seletor`=7 with N_IN=7 → `in_ready`=0 and no new `out_valid`. With the macro, `sel_err`=1 one cycle later; a `sel_load` of 2 clears it at the next edge.
- Same-cycle load: `sel_load` with 5 while transferring from source 1 → that `out_src` is 1 and the next transfer has `out_src`=5.
- Reset asserted with `out_valid`=1 and `out_ready`=0 → after the edge `out_valid`=0, `out`=0 and `sel_q`=0.
